// File: rtl/exc_sched_pkg.sv
// Shared CPU defines for the exception scheduler: FSM states, ExcCodes,
// exception-vector bit positions and the exception entry address.
package exc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_CP0WR = 2'd2,
      ST_REDIR = 2'd3
   } exc_state_e;

   localparam int EXC_VEC_W = 9;

   // exc_vec_i is packed {int, adel_if, ri, ov, trap, sys, bp, adel_d, ades}
   localparam int EV_INT     = 8;
   localparam int EV_ADEL_IF = 7;
   localparam int EV_RI      = 6;
   localparam int EV_OV      = 5;
   localparam int EV_TRAP    = 4;
   localparam int EV_SYS     = 3;
   localparam int EV_BP      = 2;
   localparam int EV_ADEL_D  = 1;
   localparam int EV_ADES    = 0;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;
   localparam logic [4:0] EXC_TR   = 5'd13;

   localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

   typedef struct packed {
      logic        is_exc;
      logic [4:0]  exccode;
      logic [31:0] epc;
      logic        bd;
      logic [31:0] badvaddr;
      logic        bv_we;
      logic [31:0] redir_pc;
   } exc_req_t;

endpackage

// File: rtl/exc_sched_if.sv
// MEM-stage request, CP0 write and fetch-redirect signals of the exception scheduler.
interface exc_sched_if;
   import exc_sched_pkg::*;

   logic                 mem_valid_i;
   logic [31:0]          mem_pc_i;
   logic                 mem_bd_i;
   logic [EXC_VEC_W-1:0] exc_vec_i;
   logic                 eret_i;
   logic [31:0]          badvaddr_i;
   logic [31:0]          epc_i;
   logic                 redirect_ready_i;

   logic                 busy_o;
   logic                 flush_o;
   logic                 cp0_we_o;
   logic                 cp0_eret_o;
   logic [4:0]           cp0_exccode_o;
   logic [31:0]          cp0_epc_o;
   logic                 cp0_bd_o;
   logic [31:0]          cp0_badvaddr_o;
   logic                 cp0_bv_we_o;
   logic                 redirect_valid_o;
   logic [31:0]          redirect_pc_o;

   modport slave (
      input  mem_valid_i, mem_pc_i, mem_bd_i, exc_vec_i, eret_i, badvaddr_i, epc_i,
             redirect_ready_i,
      output busy_o, flush_o, cp0_we_o, cp0_eret_o, cp0_exccode_o, cp0_epc_o, cp0_bd_o,
             cp0_badvaddr_o, cp0_bv_we_o, redirect_valid_o, redirect_pc_o
   );

   modport master (
      output mem_valid_i, mem_pc_i, mem_bd_i, exc_vec_i, eret_i, badvaddr_i, epc_i,
             redirect_ready_i,
      input  busy_o, flush_o, cp0_we_o, cp0_eret_o, cp0_exccode_o, cp0_epc_o, cp0_bd_o,
             cp0_badvaddr_o, cp0_bv_we_o, redirect_valid_o, redirect_pc_o
   );

endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority cause encoder: picks the highest pending exception and
// reports its ExcCode and whether it updates BadVAddr.
module exc_prio_enc
   import exc_sched_pkg::*;
(
   input  logic [EXC_VEC_W-1:0] exc_vec_i,
   output logic [4:0]           exccode_o,
   output logic                 hit_o,
   output logic                 bv_we_o
);

   always_comb begin
      exccode_o = EXC_INT;
      bv_we_o   = 1'b0;
      hit_o     = |exc_vec_i;
      if (exc_vec_i[EV_INT])            exccode_o = EXC_INT;
      else if (exc_vec_i[EV_ADEL_IF]) begin
         exccode_o = EXC_ADEL;
         bv_we_o   = 1'b1;
      end
      else if (exc_vec_i[EV_RI])        exccode_o = EXC_RI;
      else if (exc_vec_i[EV_OV])        exccode_o = EXC_OV;
      else if (exc_vec_i[EV_TRAP])      exccode_o = EXC_TR;
      else if (exc_vec_i[EV_SYS])       exccode_o = EXC_SYS;
      else if (exc_vec_i[EV_BP])        exccode_o = EXC_BP;
      else if (exc_vec_i[EV_ADEL_D]) begin
         exccode_o = EXC_ADEL;
         bv_we_o   = 1'b1;
      end
      else if (exc_vec_i[EV_ADES]) begin
         exccode_o = EXC_ADES;
         bv_we_o   = 1'b1;
      end
   end

endmodule

// File: rtl/exc_sched.sv
// Exception/ERET scheduler: captures a MEM-stage request, then sequences
// pipeline flush, CP0 update and fetch redirect.
module exc_sched
   import exc_sched_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   exc_sched_if.slave  bus
);

   exc_state_e state, nxt;
   exc_req_t   cap, cap_d;
   logic [4:0] enc_code;
   logic       enc_hit, enc_bv_we, req_hit;

   exc_prio_enc u_prio (
      .exc_vec_i (bus.exc_vec_i),
      .exccode_o (enc_code),
      .hit_o     (enc_hit),
      .bv_we_o   (enc_bv_we)
   );

   assign req_hit = bus.mem_valid_i && (enc_hit || bus.eret_i);

   // Exceptions win over ERET: an ERET payload is only used when no cause bit is set.
   always_comb begin
      cap_d          = '0;
      cap_d.is_exc   = enc_hit;
      cap_d.exccode  = enc_code;
      cap_d.bd       = bus.mem_bd_i;
      cap_d.epc      = bus.mem_bd_i ? bus.mem_pc_i - 32'd4 : bus.mem_pc_i;
      cap_d.bv_we    = enc_bv_we;
      if (enc_bv_we)
         cap_d.badvaddr = (!bus.exc_vec_i[EV_INT] && bus.exc_vec_i[EV_ADEL_IF]) ?
                          bus.mem_pc_i : bus.badvaddr_i;
      cap_d.redir_pc = enc_hit ? EXC_VECTOR : bus.epc_i;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
         cap   <= '0;
      end else begin
         state <= nxt;
         if (state == ST_IDLE && req_hit) cap <= cap_d;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:  if (req_hit) nxt = ST_FLUSH;
         ST_FLUSH: nxt = ST_CP0WR;
         ST_CP0WR: nxt = ST_REDIR;
         ST_REDIR: if (bus.redirect_ready_i) nxt = ST_IDLE;
         default:  nxt = ST_IDLE;
      endcase
   end

   assign bus.busy_o           = (state != ST_IDLE);
   assign bus.flush_o          = (state == ST_FLUSH);
   assign bus.cp0_we_o         = (state == ST_CP0WR) &&  cap.is_exc;
   assign bus.cp0_eret_o       = (state == ST_CP0WR) && !cap.is_exc;
   assign bus.cp0_exccode_o    = cap.exccode;
   assign bus.cp0_epc_o        = cap.epc;
   assign bus.cp0_bd_o         = cap.bd;
   assign bus.cp0_badvaddr_o   = cap.badvaddr;
   assign bus.cp0_bv_we_o      = bus.cp0_we_o && cap.bv_we;
   assign bus.redirect_valid_o = (state == ST_REDIR);
   assign bus.redirect_pc_o    = cap.redir_pc;

endmodule

// File: tb/tb_exc_sched.sv
// Randomised + directed bench for exc_sched against a cycle-age reference model.
module tb_exc_sched;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   exc_sched_if bus ();
   exc_sched dut (.clk(clk), .resetn(resetn), .bus(bus));

   always #5 clk = ~clk;

   // Model: a request is "active" for `age` cycles after its capture edge.
   bit          m_act;
   int          m_age;
   bit          m_exc, m_bd, m_bvwe;
   logic [4:0]  m_code;
   logic [31:0] m_epc, m_bva, m_rpc;

   int          pr_bit [9] = '{8, 7, 6, 5, 4, 3, 2, 1, 0};
   logic [4:0]  pr_code[9] = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd13, 5'd8, 5'd9, 5'd4, 5'd5};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_act = 0;
         m_age = 0;
      end else if (m_act) begin
         if (m_age >= 3 && bus.redirect_ready_i) m_act = 0;
         else m_age++;
      end else if (bus.mem_valid_i && (bus.exc_vec_i != 0 || bus.eret_i)) begin
         m_act  = 1;
         m_age  = 1;
         m_exc  = (bus.exc_vec_i != 0);
         m_bd   = bus.mem_bd_i;
         m_epc  = bus.mem_bd_i ? bus.mem_pc_i - 4 : bus.mem_pc_i;
         m_rpc  = m_exc ? 32'hBFC00380 : bus.epc_i;
         m_code = 0;
         m_bvwe = 0;
         m_bva  = 0;
         for (int i = 0; i < 9; i++) begin
            if (bus.exc_vec_i[pr_bit[i]]) begin
               m_code = pr_code[i];
               m_bvwe = (pr_bit[i] == 7 || pr_bit[i] <= 1);
               m_bva  = (pr_bit[i] == 7) ? bus.mem_pc_i : bus.badvaddr_i;
               break;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_busy", 32'(bus.busy_o), 0);
         chk("rst_outs", 32'({bus.flush_o, bus.cp0_we_o, bus.cp0_eret_o, bus.redirect_valid_o,
                              bus.cp0_bv_we_o, bus.cp0_bd_o}), 0);
         chk("rst_pc", bus.redirect_pc_o | bus.cp0_epc_o | bus.cp0_badvaddr_o, 0);
      end else begin
         chk("busy", 32'(bus.busy_o), 32'(m_act));
         chk("flush", 32'(bus.flush_o), 32'(m_act && m_age == 1));
         chk("cp0_we", 32'(bus.cp0_we_o), 32'(m_act && m_age == 2 && m_exc));
         chk("cp0_eret", 32'(bus.cp0_eret_o), 32'(m_act && m_age == 2 && !m_exc));
         chk("bv_we", 32'(bus.cp0_bv_we_o), 32'(m_act && m_age == 2 && m_exc && m_bvwe));
         chk("redir_v", 32'(bus.redirect_valid_o), 32'(m_act && m_age >= 3));
         if (m_act && m_age == 2 && m_exc) begin
            chk("exccode", 32'(bus.cp0_exccode_o), 32'(m_code));
            chk("epc", bus.cp0_epc_o, m_epc);
            chk("bd", 32'(bus.cp0_bd_o), 32'(m_bd));
            if (m_bvwe) chk("badvaddr", bus.cp0_badvaddr_o, m_bva);
         end
         if (m_act && m_age >= 3) chk("redir_pc", bus.redirect_pc_o, m_rpc);
      end
   end

   task automatic clr();
      bus.mem_valid_i = 0;
      bus.mem_pc_i    = 0;
      bus.mem_bd_i    = 0;
      bus.exc_vec_i   = 0;
      bus.eret_i      = 0;
      bus.badvaddr_i  = 0;
      bus.epc_i       = 0;
   endtask

   // Drive one request at a negedge; returns at the negedge of cycle 1 (flush).
   task automatic req(input logic [31:0] pc, input logic bd, input logic [8:0] vec,
                      input logic eret, input logic [31:0] bva, input logic [31:0] epc);
      bus.mem_valid_i = 1;
      bus.mem_pc_i    = pc;
      bus.mem_bd_i    = bd;
      bus.exc_vec_i   = vec;
      bus.eret_i      = eret;
      bus.badvaddr_i  = bva;
      bus.epc_i       = epc;
      @(negedge clk);
      clr();
   endtask

   initial begin
      clr();
      bus.redirect_ready_i = 1;
      #1;
      chk("reset_busy", 32'(bus.busy_o), 0);
      @(negedge clk);
      resetn = 1;
      @(negedge clk);

      // trap only
      req(32'h80001000, 0, 9'b000010000, 0, 0, 0);
      chk("t1_flush", 32'(bus.flush_o), 1);
      @(negedge clk);
      chk("t1_we", 32'(bus.cp0_we_o), 1);
      chk("t1_code", 32'(bus.cp0_exccode_o), 13);
      chk("t1_epc", bus.cp0_epc_o, 32'h80001000);
      @(negedge clk);
      chk("t1_redir", bus.redirect_pc_o, 32'hBFC00380);
      chk("t1_rv", 32'(bus.redirect_valid_o), 1);
      @(negedge clk);
      chk("t1_idle", 32'(bus.busy_o), 0);

      // ov+trap+sys in a delay slot
      req(32'h80002004, 1, 9'b000111000, 0, 0, 0);
      @(negedge clk);
      chk("t2_code", 32'(bus.cp0_exccode_o), 12);
      chk("t2_epc", bus.cp0_epc_o, 32'h80002000);
      chk("t2_bd", 32'(bus.cp0_bd_o), 1);
      repeat (2) @(negedge clk);

      // ades, together with eret (exception wins)
      req(32'h80002100, 0, 9'b000000001, 1, 32'h00000003, 32'h12345678);
      @(negedge clk);
      chk("t3_code", 32'(bus.cp0_exccode_o), 5);
      chk("t3_bva", bus.cp0_badvaddr_o, 32'h00000003);
      chk("t3_bvwe", 32'(bus.cp0_bv_we_o), 1);
      chk("t3_eret", 32'(bus.cp0_eret_o), 0);
      repeat (2) @(negedge clk);

      // eret
      req(32'h80002200, 0, 0, 1, 0, 32'h80003000);
      @(negedge clk);
      chk("t4_eret", 32'(bus.cp0_eret_o), 1);
      chk("t4_we", 32'(bus.cp0_we_o), 0);
      @(negedge clk);
      chk("t4_redir", bus.redirect_pc_o, 32'h80003000);
      @(negedge clk);

      // back-pressure in REDIR; new requests must be ignored
      bus.redirect_ready_i = 0;
      req(32'h80004000, 0, 9'b000010000, 0, 0, 0);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("t5_rv", 32'(bus.redirect_valid_o), 1);
         chk("t5_pc", bus.redirect_pc_o, 32'hBFC00380);
         chk("t5_busy", 32'(bus.busy_o), 1);
         bus.mem_valid_i = 1;
         bus.exc_vec_i   = 9'b000010000;
         bus.mem_pc_i    = 32'h8000_5000 + 32'(i);
         @(negedge clk);
      end
      clr();
      bus.redirect_ready_i = 1;
      @(negedge clk);
      chk("t5_idle", 32'(bus.busy_o), 0);

      // reset during CP0WR
      req(32'h80006000, 0, 9'b100000000, 0, 0, 0);
      @(negedge clk);
      #2 resetn = 0;
      #1;
      chk("t6_we", 32'(bus.cp0_we_o), 0);
      chk("t6_busy", 32'(bus.busy_o), 0);
      chk("t6_code", 32'(bus.cp0_exccode_o), 0);
      @(negedge clk);
      resetn = 1;
      @(negedge clk);
      chk("t6_idle", 32'(bus.busy_o), 0);

      // randomised traffic
      for (int n = 0; n < 600; n++) begin
         bus.mem_valid_i      = ($urandom_range(0, 9) < 6);
         bus.mem_pc_i         = $urandom & 32'hFFFF_FFFC;
         bus.mem_bd_i         = 1'($urandom);
         case ($urandom_range(0, 3))
            0:       bus.exc_vec_i = 9'($urandom);
            1, 2:    bus.exc_vec_i = 9'(1 << $urandom_range(0, 8));
            default: bus.exc_vec_i = 0;
         endcase
         bus.eret_i           = ($urandom_range(0, 4) == 0);
         bus.badvaddr_i       = $urandom;
         bus.epc_i            = $urandom;
         bus.redirect_ready_i = 1'($urandom);
         @(negedge clk);
      end
      clr();
      bus.redirect_ready_i = 1;
      repeat (8) @(negedge clk);
      chk("drain_idle", 32'(bus.busy_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/exc_sched.md
EXC_SCHED -- requirements
Module: exc_sched

Interface
REQ-001 SHALL have ports: clk  input  1  system clock (rising edge).
REQ-002 SHALL have ports: resetn  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: mem_valid_i  input  1  MEM-stage instruction valid.
REQ-004 SHALL have ports: mem_pc_i  input  32  MEM-stage PC.
REQ-005 SHALL have ports: mem_bd_i  input  1  MEM instruction is in a delay slot.
REQ-006 SHALL have ports: exc_vec_i  input  9  flags {int, adel_if, ri, ov, trap, sys, bp, adel_d, ades}; trap is the EXE trap-compare result carried down the pipeline.
REQ-007 SHALL have ports: eret_i  input  1  MEM instruction is ERET.
REQ-008 SHALL have ports: badvaddr_i  input  32  faulting data address.
REQ-009 SHALL have ports: epc_i  input  32  current CP0 EPC.
REQ-010 SHALL have ports: redirect_ready_i  input  1  fetch accepts redirect.
REQ-011 SHALL have ports: busy_o  output  1  stall request to pipeline.
REQ-012 SHALL have ports: flush_o  output  1  one-cycle flush of IF..MEM.
REQ-013 SHALL have ports: cp0_we_o  output  1  CP0 exception-state write strobe.
REQ-014 SHALL have ports: cp0_eret_o  output  1  CP0 EXL-clear strobe.
REQ-015 SHALL have ports: cp0_exccode_o  output  5, cp0_epc_o  output  32, cp0_bd_o  output  1, cp0_badvaddr_o  output  32, cp0_bv_we_o  output  1  CP0 write payload.
REQ-016 SHALL have ports: redirect_valid_o  output  1, redirect_pc_o  output  32  fetch redirect.

Function
REQ-017 SHALL implement FSM IDLE -> FLUSH -> CP0WR -> REDIR -> IDLE.
REQ-018 In IDLE, mem_valid_i with any exc_vec_i bit or eret_i SHALL capture request and move to FLUSH next edge; else stay IDLE.
REQ-019 Exceptions SHALL take priority over eret_i when both are set in the same cycle.
REQ-020 Cause priority SHALL be int > adel_if > ri > ov > trap > sys > bp > adel_d > ades; only the highest is recorded.
REQ-021 ExcCode SHALL be Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12, Tr=13.
REQ-022 Captured EPC SHALL be mem_pc_i-4 when mem_bd_i=1, else mem_pc_i; BD = mem_bd_i.
REQ-023 BadVAddr SHALL be mem_pc_i for adel_if and badvaddr_i for adel_d/ades; cp0_bv_we_o SHALL be set only for these three causes.
REQ-024 FLUSH SHALL assert flush_o for exactly one cycle.
REQ-025 CP0WR SHALL assert for exactly one cycle either cp0_we_o with valid payload (exception) or cp0_eret_o (eret), never both.
REQ-026 REDIR SHALL hold redirect_valid_o=1 and a stable redirect_pc_o until redirect_ready_i=1 on the same edge, then return to IDLE.
REQ-027 redirect_pc_o SHALL be 32'hBFC00380 for exceptions and epc_i sampled at capture for eret.
REQ-028 busy_o SHALL be 1 in every state except IDLE.
REQ-029 New requests SHALL be ignored outside IDLE.
REQ-030 Minimum latency from capture edge to redirect accept SHALL be 3 cycles.

Reset
REQ-031 resetn=0 SHALL asynchronously force IDLE and all outputs and captured registers to 0, including mid-sequence.
REQ-032 The first edge after resetn deasserts SHALL behave as IDLE.

Structure
REQ-033 FSM state enum, ExcCode constants, exc_vec bit indices and the exception vector address SHALL reside in the shared CPU defines package.
REQ-034 The cause priority encoder SHALL be a sub-module exc_prio_enc (exc_vec_i in; exccode, hit, bv_we out).

Verification
REQ-035 trap only, pc=0x80001000, bd=0, ready=1 -> flush cycle 1; cp0_we cycle 2 with exccode=13, epc=0x80001000; redirect 0xBFC00380 cycle 3; busy low cycle 4.
REQ-036 ov+trap+sys, bd=1, pc=0x80002004 -> exccode=12, epc=0x80002000, bd=1.
REQ-037 ades, badvaddr=0x00000003 -> exccode=5, badvaddr=0x00000003, bv_we=1.
REQ-038 eret with epc_i=0x80003000 -> cp0_eret pulse, no cp0_we, redirect 0x80003000.
REQ-039 ready held low 4 cycles in REDIR -> redirect_valid/pc stable, busy=1 throughout; new trap requests ignored.
REQ-040 resetn pulsed low during CP0WR -> all outputs 0 immediately; IDLE after release.
